ex_dispatch: RTL and testbench
==============================

// Module: ex_dispatch
// PURPOSE
//  Issue-side controller for the EX result register: accepts one decoded op per handshake, drives
//  one-hot ctrl_{addsub,mul,shift,logic,ld,br}_o at the cycle each unit's result is valid,
//  and reports writeback (wb_valid_o/wb_rd_o) aligned to the register's result output.
//  Sits between decode/issue and the EX pipeline register. Sequences multi-cycle MUL and variable-latency LD.
// PARAMETERS
//  MUL_LAT     3    cycles from MUL acceptance to result_mul valid (>=2)
//  RD_W        5    destination register index width
//  LD_TIMEOUT  255  max cycles waiting for ld_ack_i before abort (8-bit counter)
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-low
//  issue_valid_i  in   1     op offered
//  issue_ready_o  out  1     op accepted when valid&ready
//  issue_cls_i    in   3     0 ADDSUB,1 MUL,2 SHIFT,3 LOGIC,4 LD,5 BR,6-7 illegal
//  issue_rd_i     in   RD_W  destination register
//  ld_ack_i       in   1     load data valid on result_ld this cycle
//  ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o, ctrl_logic_o, ctrl_ld_o, ctrl_br_o  out 1 each, one-hot/zero
//  wb_valid_o     out  1     EX result output holds a writeback value for wb_rd_o
//  wb_rd_o        out  RD_W  writeback destination
//  illegal_o      out  1     one-cycle pulse, illegal class accepted
//  ld_timeout_o   out  1     one-cycle pulse, load aborted
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE; every ctrl_*_o, wb_valid_o, illegal_o, ld_timeout_o = 0;
//   wb_rd_o = 0. issue_ready_o = (state==IDLE) & rst; forced 0 during reset.
//  States: IDLE, MUL_WAIT, LD_WAIT. Cycle 0 = acceptance cycle.
//  IDLE, single-cycle class (ADDSUB/SHIFT/LOGIC/BR): ctrl_x_o=1 in cycle 1 only;
//   wb_valid_o=1, wb_rd_o=rd in cycle 2. Stays IDLE -> back-to-back issue, 1 op/cycle.
//  MUL: -> MUL_WAIT, ready=0, counter=MUL_LAT-1, decrement per cycle.
//   ctrl_mul_o=1 in cycle MUL_LAT. wb_valid_o in cycle MUL_LAT+1. IDLE (ready=1) in cycle MUL_LAT.
//  LD: -> LD_WAIT, ready=0. ctrl_ld_o held 1 from cycle 1 through the first cycle with ld_ack_i=1, inclusive.
//   wb_valid_o = ctrl_ld_o & ld_ack_i (combinational, matches load bypass); IDLE next cycle.
//   ld_ack_i outside LD_WAIT is ignored.
//  Load timeout: LD_TIMEOUT LD_WAIT cycles without ack -> ctrl_ld_o drops, ld_timeout_o pulses 1 cycle, IDLE.
//   No writeback.
//  Illegal class: accepted, no ctrl, no writeback, illegal_o=1 in cycle 1.
//  rd==0: ctrl still driven (result register updates); wb_valid_o suppressed.
//  Reset mid-MUL/LD: abort immediately; no late ctrl or wb pulse after reset release.
//  At most one ctrl_*_o high in any cycle (assertion).
// CONFIGURATION
//  EX_DISPATCH_PERF_EN defined: adds perf_issue_o[31:0] (accepted ops) and perf_stall_o[31:0]
//   (cycles valid&!ready). Both wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package ex_pkg: class encodings (EX_CLS_*), state enum, MUL_LAT/LD_TIMEOUT defaults.
//  Sub-module ex_wait_cnt: loadable down-counter with zero flag, shared by MUL latency and LD timeout.
// TESTING
//  ADDSUB rd=3, LOGIC rd=4, SHIFT rd=5 back-to-back -> ctrl pulses in cycles 1,2,3; wb rd 3,4,5 in cycles 2,3,4.
//  MUL rd=7 (MUL_LAT=3) with LOGIC held valid -> ready=0 cycles 1-2; ctrl_mul cycle 3, wb rd7 cycle 4;
//   LOGIC accepted cycle 3, ctrl_logic cycle 4.
//  LD rd=9, ack in cycle 4 -> ctrl_ld cycles 1-4; wb_valid cycle 4 only; ready=1 cycle 5.
//  LD, no ack (LD_TIMEOUT=255) -> ld_timeout_o pulse after 255 wait cycles; no wb; ready=1 after.
//  cls=6 -> illegal_o cycle 1, no ctrl; ADDSUB rd=0 -> ctrl_addsub, no wb_valid.
//  rst low in MUL_WAIT cycle 1 -> all outputs 0; no ctrl_mul after release; ready=1 first cycle after release.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the EX dispatch controller: class codes, FSM states, ctrl bundle.
// Default latency/timeout values used as parameter defaults by ex_dispatch.
package ex_pkg;

    localparam int unsigned EX_MUL_LAT    = 3;
    localparam int unsigned EX_LD_TIMEOUT = 255;
    localparam int unsigned EX_RD_W       = 5;
    localparam int unsigned EX_CLS_W      = 3;
    localparam int unsigned EX_CNT_W      = 8;
    localparam int unsigned EX_PERF_W     = 32;

    localparam logic [EX_CLS_W-1:0] EX_CLS_ADDSUB = 3'd0;
    localparam logic [EX_CLS_W-1:0] EX_CLS_MUL    = 3'd1;
    localparam logic [EX_CLS_W-1:0] EX_CLS_SHIFT  = 3'd2;
    localparam logic [EX_CLS_W-1:0] EX_CLS_LOGIC  = 3'd3;
    localparam logic [EX_CLS_W-1:0] EX_CLS_LD     = 3'd4;
    localparam logic [EX_CLS_W-1:0] EX_CLS_BR     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_LD_WAIT
    } ex_state_e;

    typedef struct packed {
        logic br;
        logic ld;
        logic lgc;
        logic shift;
        logic mul;
        logic addsub;
    } ex_ctrl_t;

    // One-hot result-select for a legal class; zero for illegal encodings.
    function automatic ex_ctrl_t cls_ctrl(input logic [EX_CLS_W-1:0] cls);
        ex_ctrl_t c;
        c = '0;
        case (cls)
            EX_CLS_ADDSUB: c.addsub = 1'b1;
            EX_CLS_MUL:    c.mul    = 1'b1;
            EX_CLS_SHIFT:  c.shift  = 1'b1;
            EX_CLS_LOGIC:  c.lgc    = 1'b1;
            EX_CLS_LD:     c.ld     = 1'b1;
            EX_CLS_BR:     c.br     = 1'b1;
            default:       c        = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_wait_cnt.sv
// Loadable down-counter with a zero flag; times both the MUL latency and the LD timeout.
module ex_wait_cnt import ex_pkg::*; #(
    parameter int unsigned W = EX_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Saturates at zero so a finished wait keeps reporting zero until reloaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/ex_dispatch.sv
// Issue-side sequencer for the EX result register: ctrl select timing and writeback alignment.
// Optional EX_DISPATCH_PERF_EN adds accepted-op and stall-cycle counters.
module ex_dispatch import ex_pkg::*; #(
    parameter int unsigned MUL_LAT    = EX_MUL_LAT,
    parameter int unsigned RD_W       = EX_RD_W,
    parameter int unsigned LD_TIMEOUT = EX_LD_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [EX_CLS_W-1:0] issue_cls_i,
    input  logic [RD_W-1:0]     issue_rd_i,
    input  logic                ld_ack_i,
    output logic                ctrl_addsub_o,
    output logic                ctrl_mul_o,
    output logic                ctrl_shift_o,
    output logic                ctrl_logic_o,
    output logic                ctrl_ld_o,
    output logic                ctrl_br_o,
    output logic                wb_valid_o,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic                illegal_o,
    output logic                ld_timeout_o
`ifdef EX_DISPATCH_PERF_EN
    ,
    output logic [EX_PERF_W-1:0] perf_issue_o,
    output logic [EX_PERF_W-1:0] perf_stall_o
`endif
);

    ex_state_e           state, state_d;
    ex_ctrl_t            ctrl_q, ctrl_d;
    logic                illegal_q, illegal_d;
    logic                tmo_q, tmo_d;
    logic                s1_valid_q, s1_valid_d;
    logic [RD_W-1:0]     s1_rd_q, s1_rd_d;
    logic [RD_W-1:0]     pend_rd_q, pend_rd_d;
    logic                wb_valid_q;
    logic [RD_W-1:0]     wb_rd_q;
    logic                cnt_load, cnt_zero;
    logic [EX_CNT_W-1:0] cnt_val;
    logic                accept;
    logic                ld_wb;

    assign issue_ready_o = (state == ST_IDLE) & rst;
    assign accept        = issue_valid_i & issue_ready_o;

    ex_wait_cnt #(.W(EX_CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero_c   (cnt_zero)
    );

    // Next state and next registered outputs; s1_* is the stage feeding writeback one cycle later.
    always_comb begin
        state_d    = state;
        ctrl_d     = '0;
        illegal_d  = 1'b0;
        tmo_d      = 1'b0;
        s1_valid_d = 1'b0;
        s1_rd_d    = s1_rd_q;
        pend_rd_d  = pend_rd_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (issue_cls_i)
                        EX_CLS_ADDSUB, EX_CLS_SHIFT, EX_CLS_LOGIC, EX_CLS_BR: begin
                            ctrl_d     = cls_ctrl(issue_cls_i);
                            s1_valid_d = |issue_rd_i;
                            s1_rd_d    = issue_rd_i;
                        end
                        EX_CLS_MUL: begin
                            // Count reaches zero in cycle MUL_LAT-1 so ctrl lands in cycle MUL_LAT.
                            state_d   = ST_MUL_WAIT;
                            pend_rd_d = issue_rd_i;
                            cnt_load  = 1'b1;
                            cnt_val   = EX_CNT_W'(MUL_LAT - 2);
                        end
                        EX_CLS_LD: begin
                            state_d   = ST_LD_WAIT;
                            ctrl_d    = cls_ctrl(EX_CLS_LD);
                            pend_rd_d = issue_rd_i;
                            cnt_load  = 1'b1;
                            cnt_val   = EX_CNT_W'(LD_TIMEOUT - 1);
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_zero) begin
                    state_d    = ST_IDLE;
                    ctrl_d     = cls_ctrl(EX_CLS_MUL);
                    s1_valid_d = |pend_rd_q;
                    s1_rd_d    = pend_rd_q;
                end
            end
            ST_LD_WAIT: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (ld_ack_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    ctrl_d = cls_ctrl(EX_CLS_LD);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            tmo_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_rd_q    <= '0;
            pend_rd_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            state      <= state_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            tmo_q      <= tmo_d;
            s1_valid_q <= s1_valid_d;
            s1_rd_q    <= s1_rd_d;
            pend_rd_q  <= pend_rd_d;
            wb_valid_q <= s1_valid_q;
            wb_rd_q    <= s1_rd_q;
        end
    end

    // Load data bypasses the result register, so its writeback is same-cycle with the ack.
    assign ld_wb = ctrl_q.ld & ld_ack_i & (|pend_rd_q);

    assign ctrl_addsub_o = ctrl_q.addsub;
    assign ctrl_mul_o    = ctrl_q.mul;
    assign ctrl_shift_o  = ctrl_q.shift;
    assign ctrl_logic_o  = ctrl_q.lgc;
    assign ctrl_ld_o     = ctrl_q.ld;
    assign ctrl_br_o     = ctrl_q.br;
    assign wb_valid_o    = wb_valid_q | ld_wb;
    assign wb_rd_o       = ld_wb ? pend_rd_q : wb_rd_q;
    assign illegal_o     = illegal_q;
    assign ld_timeout_o  = tmo_q;

`ifdef EX_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (accept) begin
                perf_issue_o <= perf_issue_o + EX_PERF_W'(1);
            end
            if (issue_valid_i & ~issue_ready_o) begin
                perf_stall_o <= perf_stall_o + EX_PERF_W'(1);
            end
        end
    end
`endif

    a_ctrl_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ctrl_q));

endmodule

// File: tb/tb_ex_dispatch.sv
// Randomized scoreboard bench for ex_dispatch: stimulus pushes expected events per cycle,
// a monitor pops and compares ctrl, writeback, pulse and ready behaviour each cycle.
module tb_ex_dispatch;
    import ex_pkg::*;

    localparam int unsigned RD_W       = 5;
    localparam int unsigned MUL_LAT    = 3;
    localparam int unsigned LD_TIMEOUT = 255;
    localparam int          MAXC       = 16384;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [2:0]      issue_cls_i = '0;
    logic [RD_W-1:0] issue_rd_i = '0;
    logic            ld_ack_i = 1'b0;
    logic            ctrl_addsub_o, ctrl_mul_o, ctrl_shift_o, ctrl_logic_o, ctrl_ld_o, ctrl_br_o;
    logic            wb_valid_o;
    logic [RD_W-1:0] wb_rd_o;
    logic            illegal_o, ld_timeout_o;
`ifdef EX_DISPATCH_PERF_EN
    logic [31:0]     perf_issue_o, perf_stall_o;
`endif

    ex_dispatch #(.MUL_LAT(MUL_LAT), .RD_W(RD_W), .LD_TIMEOUT(LD_TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_cls_i   (issue_cls_i),
        .issue_rd_i    (issue_rd_i),
        .ld_ack_i      (ld_ack_i),
        .ctrl_addsub_o (ctrl_addsub_o),
        .ctrl_mul_o    (ctrl_mul_o),
        .ctrl_shift_o  (ctrl_shift_o),
        .ctrl_logic_o  (ctrl_logic_o),
        .ctrl_ld_o     (ctrl_ld_o),
        .ctrl_br_o     (ctrl_br_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .illegal_o     (illegal_o),
        .ld_timeout_o  (ld_timeout_o)
`ifdef EX_DISPATCH_PERF_EN
        ,
        .perf_issue_o  (perf_issue_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events: queue 0 = ctrl one-hot (bit = class), 1 = writeback {1,rd}, 2 = {timeout,illegal}
    typedef struct { int cyc; int val; } ev_t;
    ev_t evq[3][$];
    bit  busy[MAXC];
    int  free_cyc   = 0;
    int  ld_lo      = 1;
    int  ld_hi      = 0;
    int  ld_ack_cyc = -1;
    bit  spur_en    = 1'b0;
    int  n_checks   = 0;
    int  n_pass     = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void push(int k, int c, int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        evq[k].push_back(e);
    endfunction

    function automatic int take(int k, int c);
        ev_t e;
        while (evq[k].size() > 0 && evq[k][0].cyc < c) begin
            e = evq[k].pop_front();
            check("missed_event", 32'(e.cyc), 32'(c));
        end
        if (evq[k].size() > 0 && evq[k][0].cyc == c) begin
            e = evq[k].pop_front();
            return e.val;
        end
        return 0;
    endfunction

    // Reference behaviour: an op accepted at cycle t schedules its whole future from the class rules.
    function automatic void model_accept(int t, int cls, int rd, int dly);
        int fin;
        int last;
        case (cls)
            0, 2, 3, 5: begin
                push(0, t + 1, 1 << cls);
                if (rd != 0) push(1, t + 2, (1 << RD_W) | rd);
                fin = t + 1;
            end
            1: begin
                push(0, t + MUL_LAT, 2);
                if (rd != 0) push(1, t + MUL_LAT + 1, (1 << RD_W) | rd);
                fin = t + MUL_LAT;
            end
            4: begin
                last = (dly <= LD_TIMEOUT) ? dly : LD_TIMEOUT;
                for (int k = 1; k <= last; k++) push(0, t + k, 16);
                ld_lo = t + 1;
                ld_hi = t + last;
                if (dly <= LD_TIMEOUT) begin
                    ld_ack_cyc = t + dly;
                    if (rd != 0) push(1, t + dly, (1 << RD_W) | rd);
                    fin = t + dly + 1;
                end else begin
                    ld_ack_cyc = -1;
                    push(2, t + LD_TIMEOUT + 1, 2);
                    fin = t + LD_TIMEOUT + 1;
                end
            end
            default: begin
                push(2, t + 1, 1);
                fin = t + 1;
            end
        endcase
        for (int i = t + 1; i < fin; i++) if (i < MAXC) busy[i] = 1'b1;
        free_cyc = fin;
    endfunction

    // Load acknowledge driver: scheduled ack inside the window, optional noise outside it.
    always @(negedge clk) begin
        if (cyc == ld_ack_cyc) ld_ack_i = 1'b1;
        else if (cyc >= ld_lo && cyc <= ld_hi) ld_ack_i = 1'b0;
        else ld_ack_i = spur_en && ($urandom_range(0, 3) == 0);
    end

    logic [31:0] mob, mex;
    int          mc;
    always @(negedge clk) begin
        #1;
        mc = cyc;
        check("ready", 32'(issue_ready_o), 32'(rst && !busy[mc]));
        mob = 32'({ctrl_br_o, ctrl_ld_o, ctrl_logic_o, ctrl_shift_o, ctrl_mul_o, ctrl_addsub_o});
        mex = 32'(take(0, mc));
        if (mob != 0 || mex != 0) check("ctrl", mob, mex);
        mob = wb_valid_o ? (32'(1 << RD_W) | 32'(wb_rd_o)) : 32'd0;
        mex = 32'(take(1, mc));
        if (mob != 0 || mex != 0) check("wb", mob, mex);
        mob = 32'({ld_timeout_o, illegal_o});
        mex = 32'(take(2, mc));
        if (mob != 0 || mex != 0) check("pulse", mob, mex);
    end

    task automatic check_quiet(string tag);
        check({tag, "_ctrl"}, 32'({ctrl_br_o, ctrl_ld_o, ctrl_logic_o, ctrl_shift_o, ctrl_mul_o, ctrl_addsub_o}), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, "_illegal"}, 32'(illegal_o), 32'd0);
        check({tag, "_timeout"}, 32'(ld_timeout_o), 32'd0);
        check({tag, "_ready"}, 32'(issue_ready_o), 32'd0);
    endtask

    // Entered right after a falling edge; returns right after a falling edge.
    task automatic issue(input int cls, input int rd, input int dly);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        issue_valid_i = 1'b1;
        issue_cls_i = 3'(cls);
        issue_rd_i = RD_W'(rd);
        while (!done) begin
            if (rst && cyc >= free_cyc) begin
                model_accept(cyc, cls, rd, dly);
                done = 1'b1;
            end else if (waited > 600) begin
                n_checks++;
                $display("FAIL issue_wait: waited %0d cycles, required acceptance", waited);
                done = 1'b1;
            end
            waited++;
            @(negedge clk);
        end
        issue_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mid_reset();
        int c;
        int old_free;
        c = cyc;
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            while (evq[k].size() > 0 && evq[k][$].cyc > c) void'(evq[k].pop_back());
        ld_ack_cyc = -1;
        if (ld_hi >= c) ld_hi = c + 1;
        old_free = free_cyc;
        @(negedge clk);
        #3;
        check_quiet("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = cyc; i < old_free && i < MAXC; i++) busy[i] = 1'b0;
        free_cyc = cyc;
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b1;
        free_cyc = cyc;

        issue(0, 3, 0); issue(3, 4, 0); issue(2, 5, 0);
        idle(3);
        issue(1, 7, 0); issue(3, 8, 0);
        idle(3);
        issue(4, 9, 4);
        idle(3);
        issue(4, 10, 255);
        idle(2);
        issue(4, 11, 400);
        idle(3);
        issue(6, 12, 0); issue(7, 1, 0); issue(0, 0, 0); issue(5, 31, 0); issue(4, 0, 3); issue(1, 0, 0);
        idle(3);

        issue(1, 13, 0);
        mid_reset();
        issue(5, 14, 0);
        idle(2);
        issue(4, 15, 20);
        idle(1);
        mid_reset();
        issue(2, 16, 0);
        idle(3);

        spur_en = 1'b1;
        repeat (150) begin
            issue($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(2, 12));
            idle($urandom_range(0, 2));
        end
        spur_en = 1'b0;

        idle(20);
        #3;
        for (int k = 0; k < 3; k++) check("queue_drained", 32'(evq[k].size()), 32'd0);
        summary();
        $finish;
    end

    initial begin
        #1_000_000;
        n_checks++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        summary();
        $finish;
    end

endmodule
